seq_mul_hs: RTL and testbench

//  Parametrised iterative shift-add multiplier. Replaces the single-cycle 8x8 combinational multiplier.

---
 rtl/seq_mul_hs_pkg.sv | 12 +
 rtl/seq_mul_hs_if.sv | 27 ++
 rtl/seq_mul_hs.sv | 105 ++++++++++
 tb/tb_seq_mul_hs.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mul_hs_pkg.sv
// Shared types and limits for the iterative shift-add multiplier.
package seq_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_e;

    localparam int MAX_WIDTH = 32;

endpackage

// File: rtl/seq_mul_hs_if.sv
// Operand/result handshake bundle between producer, multiplier and consumer.
interface seq_mul_hs_if #(
    parameter int WIDTH = 8
);
    // Valid/ready: a transfer happens on a rising edge where valid and ready are both high;
    // a source holds valid and its data steady until that edge, ready never depends on valid.
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 signed_mode;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   y;
    logic                 busy;

    modport master (
        output in_valid, a, b, signed_mode, out_ready,
        input  in_ready, out_valid, y, busy
    );

    modport slave (
        input  in_valid, a, b, signed_mode, out_ready,
        output in_ready, out_valid, y, busy
    );

endinterface

// File: rtl/seq_mul_hs.sv
// Iterative shift-add multiplier: one multiplier bit per clock, sign handled as
// magnitude multiply plus a final conditional negate.
module seq_mul_hs
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    seq_mul_hs_if.slave  bus,
    output mul_state_e   dbg_state_o
);

    localparam int CW = $clog2(WIDTH) + 1;

    if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("seq_mul_hs: WIDTH out of range");
    end

    mul_state_e           state_q, state_d;
    logic [2*WIDTH-1:0]   acc_q;
    logic [2*WIDTH-1:0]   acc_d;
    logic [WIDTH-1:0]     mcand_q;
    logic [WIDTH-1:0]     mplier_q;
    logic [CW-1:0]        count_q;
    logic                 neg_q;
    logic [2*WIDTH-1:0]   y_q;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic                 last_step;

    // The most-negative operand negates to 2^(WIDTH-1), still representable unsigned.
    always_comb begin
        a_mag = (bus.signed_mode && bus.a[WIDTH-1]) ? (~bus.a + 1'b1) : bus.a;
        b_mag = (bus.signed_mode && bus.b[WIDTH-1]) ? (~bus.b + 1'b1) : bus.b;
    end

    assign last_step = (count_q == CW'(WIDTH - 1));

    always_comb begin
        acc_d = acc_q;
        if (mplier_q[0]) begin
            acc_d = acc_q + ({{WIDTH{1'b0}}, mcand_q} << count_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid)  state_d = BUSY;
            BUSY:    if (last_step)     state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.busy      = (state_q == BUSY);
        bus.out_valid = (state_q == DONE);
        bus.y         = y_q;
        dbg_state_o   = state_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            count_q  <= '0;
            neg_q    <= 1'b0;
            y_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        mcand_q  <= a_mag;
                        mplier_q <= b_mag;
                        neg_q    <= bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        acc_q    <= '0;
                        count_q  <= '0;
                    end
                end
                BUSY: begin
                    acc_q    <= acc_d;
                    mplier_q <= mplier_q >> 1;
                    count_q  <= count_q + CW'(1);
                    if (last_step) begin
                        y_q <= neg_q ? (~acc_d + 1'b1) : acc_d;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mul_hs.sv
// Bench for seq_mul_hs at WIDTH=8 and WIDTH=16 against an integer-arithmetic reference.
module tb_seq_mul_hs;
    import seq_mul_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       rand_rdy;
    logic       force_rdy;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    mul_state_e st8, st16;

    seq_mul_hs_if #(.WIDTH(8))  b8();
    seq_mul_hs_if #(.WIDTH(16)) b16();

    seq_mul_hs #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(b8.slave),  .dbg_state_o(st8));
    seq_mul_hs #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16.slave), .dbg_state_o(st16));

    always @(posedge clk) cyc++;

    // Consumer back-pressure: fixed level or random stalls.
    always @(posedge clk) begin
        #2;
        b8.out_ready  = rand_rdy ? ($urandom_range(0, 3) != 0) : force_rdy;
        b16.out_ready = rand_rdy ? ($urandom_range(0, 2) != 0) : force_rdy;
    end

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference product: interpret operands as integers, multiply, keep 2*w bits.
    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                             input logic sm, input int w);
        longint sa, sb, p, mask;
        sa = longint'(a);
        sb = longint'(b);
        if (sm && a[w-1]) sa = sa - (longint'(1) << w);
        if (sm && b[w-1]) sb = sb - (longint'(1) << w);
        p    = sa * sb;
        mask = (longint'(1) << (2 * w)) - 1;
        return 64'(p & mask);
    endfunction

    // Scoreboards: one entry per accepted pair until the result is consumed.
    logic [15:0] exp8_q[$];
    logic [31:0] exp16_q[$];
    int edge8 = 0, in8 = 0, out8 = 0, ab8 = 0;
    int edge16 = 0, in16 = 0, out16 = 0, ab16 = 0;

    always @(negedge clk) begin
        int  d;
        bit  full;
        if (!rst_n) begin
            ab8 += exp8_q.size();
            exp8_q.delete();
        end else begin
            d    = cyc - edge8;
            full = (exp8_q.size() != 0);
            check("in_ready8", b8.in_ready, !full);
            check("busy8", b8.busy, full && d < 8);
            check("out_valid8", b8.out_valid, full && d >= 8);
            if (full && d >= 8) begin
                check("y8", b8.y, exp8_q[0]);
                if (b8.out_ready) begin
                    void'(exp8_q.pop_front());
                    out8++;
                end
            end else if (!full && b8.in_valid) begin
                exp8_q.push_back(16'(ref_prod(32'(b8.a), 32'(b8.b), b8.signed_mode, 8)));
                edge8 = cyc + 1;
                in8++;
            end
        end
    end

    always @(negedge clk) begin
        int  d;
        bit  full;
        if (!rst_n) begin
            ab16 += exp16_q.size();
            exp16_q.delete();
        end else begin
            d    = cyc - edge16;
            full = (exp16_q.size() != 0);
            check("in_ready16", b16.in_ready, !full);
            check("busy16", b16.busy, full && d < 16);
            check("out_valid16", b16.out_valid, full && d >= 16);
            if (full && d >= 16) begin
                check("y16", b16.y, exp16_q[0]);
                if (b16.out_ready) begin
                    void'(exp16_q.pop_front());
                    out16++;
                end
            end else if (!full && b16.in_valid) begin
                exp16_q.push_back(32'(ref_prod(32'(b16.a), 32'(b16.b), b16.signed_mode, 16)));
                edge16 = cyc + 1;
                in16++;
            end
        end
    end

    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic sm);
        int n = 0;
        b8.a = a; b8.b = b; b8.signed_mode = sm; b8.in_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!b8.in_ready && n < 300);
        if (!b8.in_ready) check("send8_timeout", 0, 1);
        @(posedge clk); #1;
        b8.in_valid = 1'b0;
        b8.a = 8'($urandom); b8.b = 8'($urandom); b8.signed_mode = 1'($urandom);
    endtask

    task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic sm);
        int n = 0;
        b16.a = a; b16.b = b; b16.signed_mode = sm; b16.in_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!b16.in_ready && n < 300);
        if (!b16.in_ready) check("send16_timeout", 0, 1);
        @(posedge clk); #1;
        b16.in_valid = 1'b0;
        b16.a = 16'($urandom); b16.b = 16'($urandom); b16.signed_mode = 1'($urandom);
    endtask

    task automatic drain8();
        int n = 0;
        while (exp8_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (exp8_q.size() != 0) check("drain8_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic drain16();
        int n = 0;
        while (exp16_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (exp16_q.size() != 0) check("drain16_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic wait_out8();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!b8.out_valid && n < 100);
        if (!b8.out_valid) check("out8_timeout", 0, 1);
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic sm,
                        input logic [15:0] exp, input string name);
        send8(a, b, sm);
        wait_out8();
        check(name, b8.y, exp);
        drain8();
    endtask

    initial begin
        logic [15:0] y_hold;
        rst_n = 1'b0; rand_rdy = 1'b0; force_rdy = 1'b1;
        b8.in_valid = 1'b1;  b8.a = 8'd3;  b8.b = 8'd4;  b8.signed_mode = 1'b0;
        b16.in_valid = 1'b0; b16.a = '0;   b16.b = '0;   b16.signed_mode = 1'b0;

        // Model pinned to hand-computed values.
        check("model_uu_255", ref_prod(32'd255, 32'd255, 1'b0, 8), 64'd65025);
        check("model_ss_m128", ref_prod(32'h80, 32'h80, 1'b1, 8), 64'd16384);
        check("model_ss_m1x1", ref_prod(32'hFF, 32'h01, 1'b1, 8), 64'hFFFF);
        check("model_16_m1xm1", ref_prod(32'hFFFF, 32'hFFFF, 1'b1, 16), 64'd1);

        // Reset held with a pending request.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", b8.in_ready, 1);
        check("rst_out_valid", b8.out_valid, 0);
        check("rst_busy", b8.busy, 0);
        check("rst_y", b8.y, 0);
        check("rst_state", st8, IDLE);
        check("rst_y16", b16.y, 0);
        b8.in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed products with literal expectations.
        run8(8'd255, 8'd255, 1'b0, 16'hFE01, "lit_255x255");
        run8(8'h80, 8'h80, 1'b1, 16'd16384, "lit_m128xm128");
        run8(8'h80, 8'h7F, 1'b1, 16'hC080, "lit_m128x127");
        run8(8'hFF, 8'h01, 1'b1, 16'hFFFF, "lit_m1x1");
        run8(8'h00, 8'hFB, 1'b1, 16'h0000, "lit_0xm5");

        // Consumer stalls while a new pair waits.
        force_rdy = 1'b0;
        send8(8'd13, 8'd11, 1'b0);
        wait_out8();
        check("bp_y", b8.y, 16'd143);
        y_hold = b8.y;
        @(posedge clk); #1;
        b8.a = 8'd5; b8.b = 8'd6; b8.signed_mode = 1'b0; b8.in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("bp_valid_held", b8.out_valid, 1);
            check("bp_y_held", b8.y, y_hold);
            check("bp_in_ready", b8.in_ready, 0);
        end
        @(posedge clk); #1;
        force_rdy = 1'b1;
        send8(8'd5, 8'd6, 1'b0);
        wait_out8();
        check("bp_next_y", b8.y, 16'd30);
        drain8();

        // Abort mid-multiply when the step counter is at 4.
        send8(8'd100, 8'd100, 1'b0);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_state", st8, IDLE);
        check("abort_out_valid", b8.out_valid, 0);
        @(posedge clk); #1;
        run8(8'd3, 8'd7, 1'b0, 16'd21, "lit_after_abort");

        // Randomised traffic with consumer stalls.
        rand_rdy = 1'b1;
        for (int i = 0; i < 200; i++) begin
            send8(($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom), 8'($urandom),
                  1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        drain8();
        for (int i = 0; i < 200; i++) begin
            send16(($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom), 16'($urandom),
                   1'($urandom_range(0, 1)));
        end
        drain16();

        check("txn8_balance", 64'(in8), 64'(out8 + ab8));
        check("txn8_aborted", 64'(ab8), 1);
        check("txn16_balance", 64'(in16), 64'(out16 + ab16));
        check("txn16_count", 64'(out16), 200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
